// File: rtl/sort_pkg.sv
// sort_pkg
// Shared types and helpers for the streaming sorter control slice.
//   sort_state_t : controller states (IDLE, LOAD, SORT, OUTPUT, CLEAR)
//   maxlen()     : maximum packet length in words for a given RAM address width
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE_S,
    LOAD_S,
    SORT_S,
    OUTPUT_S,
    CLEAR_S
  } sort_state_t;

  function automatic int maxlen(input int awidth);
    return 1 << awidth;
  endfunction

endpackage

// File: rtl/sort_stream_ctrl_if.sv
// sort_stream_ctrl_if
// Avalon-ST-like packet qualifier bundle (no data; data lives in the sort RAM).
//   valid, sop, eop : driven by the stream source (master)
//   ready           : driven by the stream sink (slave)
interface sort_stream_ctrl_if;
  logic valid;
  logic sop;
  logic eop;
  logic ready;

  modport master (output valid, output sop, output eop, input ready);
  modport slave  (input valid, input sop, input eop, output ready);
endinterface

// File: rtl/sort_rd_sequencer.sv
// sort_rd_sequencer
// Read side of the sorter: walks the RAM from address 0 to len-1 and turns the
// 1-cycle-latency RAM output into a valid/sop/eop stream with backpressure.
//   clk_i, srst_n_i : clock, synchronous active-low reset
//   start_i         : pulse, arms the sequencer with the read pointer at 0
//   len_i           : number of words to stream (1..2**AWIDTH)
//   src_ready_i     : downstream ready
//   rd_en_o/rd_addr_o : RAM read strobe and address
//   src_valid_o/src_sop_o/src_eop_o : stream qualifiers aligned with RAM q
//   done_o          : final handshake (valid & ready & eop)
module sort_rd_sequencer #(
  parameter int AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic              start_i,
  input  logic [AWIDTH:0]   len_i,
  input  logic              src_ready_i,
  output logic              rd_en_o,
  output logic [AWIDTH-1:0] rd_addr_o,
  output logic              src_valid_o,
  output logic              src_sop_o,
  output logic              src_eop_o,
  output logic              done_o
);

  logic            active_reg, active_next;
  logic [AWIDTH:0] ptr_reg, ptr_next;
  logic            valid_reg, valid_next;
  logic            sop_reg, sop_next;
  logic            eop_reg, eop_next;
  logic            issue;

  // A new read may only be issued when the output slot is free or being
  // emptied this cycle; RAM q holds while no read is issued, so a stalled
  // word stays stable on the output.
  assign issue     = active_reg && (ptr_reg < len_i) && (!valid_reg || src_ready_i);
  assign rd_en_o   = issue;
  assign rd_addr_o = ptr_reg[AWIDTH-1:0];
  assign done_o    = valid_reg && src_ready_i && eop_reg;

  assign src_valid_o = valid_reg;
  assign src_sop_o   = sop_reg;
  assign src_eop_o   = eop_reg;

  always_comb begin
    active_next = active_reg;
    ptr_next    = ptr_reg;
    valid_next  = valid_reg;
    sop_next    = sop_reg;
    eop_next    = eop_reg;

    if (start_i) begin
      active_next = 1'b1;
      ptr_next    = '0;
    end else begin
      if (issue)  ptr_next    = ptr_reg + 1'b1;
      if (done_o) active_next = 1'b0;
    end

    if (issue) begin
      valid_next = 1'b1;
      sop_next   = (ptr_reg == '0);
      eop_next   = (ptr_reg == len_i - 1'b1);
    end else if (valid_reg && src_ready_i) begin
      valid_next = 1'b0;
      sop_next   = 1'b0;
      eop_next   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      active_reg <= 1'b0;
      ptr_reg    <= '0;
      valid_reg  <= 1'b0;
      sop_reg    <= 1'b0;
      eop_reg    <= 1'b0;
    end else begin
      active_reg <= active_next;
      ptr_reg    <= ptr_next;
      valid_reg  <= valid_next;
      sop_reg    <= sop_next;
      eop_reg    <= eop_next;
    end
  end

endmodule

// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl
// Control FSM of the streaming sorter: loads an input packet into the sort
// RAM, launches the sort engine (with a guard timeout), streams the sorted
// RAM contents out and finally clears RAM/engine.
//   clk_i, srst_n_i : clock, synchronous active-low reset
//   snk (slave)     : input stream qualifiers; snk.ready high in IDLE/LOAD
//   mode_desc_i     : sort direction, latched on the accepted sop word
//   wr_en_o/wr_addr_o : combinational RAM write strobe/address
//   sort_start_o/sort_len_o/sort_desc_o/sort_done_i : sort engine handshake
//   rd_en_o/rd_addr_o : RAM read strobe/address (RAM read latency 1)
//   src (master)    : output stream qualifiers aligned with RAM q
//   clear_o         : one-cycle RAM/engine clear
//   busy_o          : high outside IDLE
//   err_ovf_o       : sticky per-packet overflow
//   err_timeout_o   : one-cycle pulse on sort timeout
module sort_stream_ctrl
  import sort_pkg::*;
#(
  parameter int AWIDTH  = 4,
  parameter int SORT_TO = 1024
) (
  input  logic                    clk_i,
  input  logic                    srst_n_i,
  sort_stream_ctrl_if.slave       snk,
  input  logic                    mode_desc_i,
  output logic                    wr_en_o,
  output logic [AWIDTH-1:0]       wr_addr_o,
  output logic                    sort_start_o,
  output logic [AWIDTH:0]         sort_len_o,
  output logic                    sort_desc_o,
  input  logic                    sort_done_i,
  output logic                    rd_en_o,
  output logic [AWIDTH-1:0]       rd_addr_o,
  sort_stream_ctrl_if.master      src,
  output logic                    clear_o,
  output logic                    busy_o,
  output logic                    err_ovf_o,
  output logic                    err_timeout_o
);

  localparam int              MAXLEN   = maxlen(AWIDTH);
  localparam logic [AWIDTH:0] MAXLEN_C = (AWIDTH+1)'(MAXLEN);
  localparam logic [AWIDTH:0] ONE_C    = (AWIDTH+1)'(1);
  localparam bit              TO_EN    = (SORT_TO != 0);
  localparam logic [31:0]     TO_LAST  = 32'(SORT_TO - 1);

  sort_state_t     state_reg, state_next;
  logic [AWIDTH:0] count_reg, count_next;
  logic [AWIDTH:0] len_reg, len_next;
  logic            desc_reg, desc_next;
  logic            ovf_reg, ovf_next;
  logic            first_reg, first_next;
  logic            to_pulse_reg, to_pulse_next;
  logic [31:0]     to_cnt_reg, to_cnt_next;

  logic accept;
  logic dropped;
  logic rd_start;
  logic rd_done;

  assign snk.ready = (state_reg == IDLE_S) || (state_reg == LOAD_S);
  assign accept    = snk.valid && snk.ready;

  // Words that do not reach the RAM: anything but a sop while idle, and
  // non-sop words once the packet already fills the RAM.
  assign dropped   = !snk.sop && ((state_reg == IDLE_S) || (count_reg == MAXLEN_C));
  assign wr_en_o   = accept && !dropped;
  assign wr_addr_o = snk.sop ? '0 : count_reg[AWIDTH-1:0];

  assign busy_o        = (state_reg != IDLE_S);
  assign clear_o       = (state_reg == CLEAR_S);
  assign sort_start_o  = first_reg;
  assign sort_len_o    = len_reg;
  assign sort_desc_o   = desc_reg;
  assign err_ovf_o     = ovf_reg;
  assign err_timeout_o = to_pulse_reg;

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    len_next      = len_reg;
    desc_next     = desc_reg;
    ovf_next      = ovf_reg;
    first_next    = 1'b0;
    to_pulse_next = 1'b0;
    to_cnt_next   = to_cnt_reg;
    rd_start      = 1'b0;

    case (state_reg)
      IDLE_S, LOAD_S: begin
        if (accept && (snk.sop || state_reg == LOAD_S)) begin
          if (snk.sop) begin
            // sop (re)starts the packet even in the middle of LOAD
            count_next = ONE_C;
            desc_next  = mode_desc_i;
            ovf_next   = 1'b0;
          end else if (dropped) begin
            ovf_next = 1'b1;
          end else begin
            count_next = count_reg + 1'b1;
          end

          if (snk.eop) begin
            len_next    = count_next;
            state_next  = SORT_S;
            first_next  = 1'b1;
            to_cnt_next = '0;
          end else begin
            state_next = LOAD_S;
          end
        end
      end

      SORT_S: begin
        to_cnt_next = to_cnt_reg + 1'b1;
        // done has priority over an expiring timeout in the same cycle
        if (sort_done_i) begin
          state_next = OUTPUT_S;
          rd_start   = 1'b1;
        end else if (TO_EN && (to_cnt_reg == TO_LAST)) begin
          to_pulse_next = 1'b1;
          state_next    = CLEAR_S;
        end
      end

      OUTPUT_S: begin
        if (rd_done) state_next = CLEAR_S;
      end

      CLEAR_S: begin
        state_next = IDLE_S;
      end

      default: begin
        state_next = IDLE_S;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_reg    <= IDLE_S;
      count_reg    <= '0;
      len_reg      <= '0;
      desc_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      first_reg    <= 1'b0;
      to_pulse_reg <= 1'b0;
      to_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      len_reg      <= len_next;
      desc_reg     <= desc_next;
      ovf_reg      <= ovf_next;
      first_reg    <= first_next;
      to_pulse_reg <= to_pulse_next;
      to_cnt_reg   <= to_cnt_next;
    end
  end

  sort_rd_sequencer #(
    .AWIDTH (AWIDTH)
  ) u_rd_seq (
    .clk_i       (clk_i),
    .srst_n_i    (srst_n_i),
    .start_i     (rd_start),
    .len_i       (len_reg),
    .src_ready_i (src.ready),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .src_valid_o (src.valid),
    .src_sop_o   (src.sop),
    .src_eop_o   (src.eop),
    .done_o      (rd_done)
  );

endmodule

// File: tb/tb_sort_stream_ctrl.sv
module tb_sort_stream_ctrl;

  localparam int AW     = 4;
  localparam int MAXLEN = 16;
  localparam int TO     = 8;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          srst_n_i;
  logic          mode_desc_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic          sort_start_o;
  logic [AW:0]   sort_len_o;
  logic          sort_desc_o;
  logic          sort_done_i;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic          clear_o;
  logic          busy_o;
  logic          err_ovf_o;
  logic          err_timeout_o;

  sort_stream_ctrl_if snk ();
  sort_stream_ctrl_if src ();

  sort_stream_ctrl #(.AWIDTH(AW), .SORT_TO(TO)) dut (
    .clk_i        (clk_i),
    .srst_n_i     (srst_n_i),
    .snk          (snk),
    .mode_desc_i  (mode_desc_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .sort_start_o (sort_start_o),
    .sort_len_o   (sort_len_o),
    .sort_desc_o  (sort_desc_o),
    .sort_done_i  (sort_done_i),
    .rd_en_o      (rd_en_o),
    .rd_addr_o    (rd_addr_o),
    .src          (src),
    .clear_o      (clear_o),
    .busy_o       (busy_o),
    .err_ovf_o    (err_ovf_o),
    .err_timeout_o(err_timeout_o)
  );

  int checks = 0;
  int failures = 0;

  // Bench-side RAM with 1-cycle read latency and q hold
  logic [7:0] ram [MAXLEN];
  logic [7:0] q;
  logic [7:0] wr_data;
  bit         model_ovf;

  typedef struct {
    logic [7:0] d;
    bit         valid;
    bit         sop;
    bit         eop;
  } word_t;
  word_t stim[$];

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    logic       do_rd;
    logic [7:0] rd_val;
    do_rd  = rd_en_o;
    rd_val = ram[rd_addr_o];
    if (wr_en_o === 1'b1) ram[wr_addr_o] = wr_data;
    @(posedge clk_i);
    if (do_rd === 1'b1) q = rd_val;
    @(negedge clk_i);
  endtask

  task automatic engine_sort();
    logic [7:0] v[$];
    for (int i = 0; i < int'(sort_len_o) && i < MAXLEN; i++) v.push_back(ram[i]);
    if (sort_desc_o) v.rsort(); else v.sort();
    for (int i = 0; i < v.size(); i++) ram[i] = v[i];
  endtask

  task automatic build_packet(input int n, input bit gaps, input bit junk);
    stim.delete();
    if (junk) stim.push_back('{8'($urandom), 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0)
        stim.push_back('{8'($urandom), 1'b0, 1'b0, 1'b0});
      stim.push_back('{8'($urandom), 1'b1, (i == 0), (i == n - 1)});
    end
  endtask

  // Drives stim[], plays sort engine and downstream sink, checks everything
  // against a packet-level model. done_delay < 0: engine never answers.
  // abort_after >= 0: pulse reset once that many words have been delivered.
  task automatic run_packet(input bit desc, input int ready_mode, input int done_delay,
                            input int abort_after, input string name);
    logic [7:0] pkt[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_d[$];
    bit got_sop[$];
    bit got_eop[$];
    bit started, exp_wr, nxt_ovf, done_seen, finished, prev_stall, prev_sop, prev_eop;
    int exp_addr, len;
    logic [7:0] prev_q;

    started = 0;
    // ---------------- load ----------------
    foreach (stim[k]) begin
      snk.valid   = stim[k].valid;
      snk.sop     = stim[k].sop;
      snk.eop     = stim[k].eop;
      wr_data     = stim[k].d;
      mode_desc_i = stim[k].sop ? desc : 1'($urandom);
      sort_done_i = 1'b0;
      src.ready   = 1'b1;
      #1;
      exp_wr   = 0;
      exp_addr = 0;
      nxt_ovf  = model_ovf;
      if (stim[k].valid) begin
        if (stim[k].sop) begin
          exp_wr = 1; exp_addr = 0; started = 1; nxt_ovf = 0;
          pkt.delete(); pkt.push_back(stim[k].d);
        end else if (started) begin
          if (pkt.size() < MAXLEN) begin
            exp_wr = 1; exp_addr = pkt.size(); pkt.push_back(stim[k].d);
          end else begin
            nxt_ovf = 1;
          end
        end
      end
      checks++;
      if (snk.ready !== 1'b1 || err_ovf_o !== model_ovf) begin
        failures++;
        $display("FAIL %s load_status word=%0d ready=%b ovf=%b required ready=1 ovf=%b",
                 name, k, snk.ready, err_ovf_o, model_ovf);
      end
      checks++;
      if (wr_en_o !== exp_wr || (exp_wr && wr_addr_o !== AW'(exp_addr))) begin
        failures++;
        $display("FAIL %s write word=%0d wr_en=%b addr=%0d required wr_en=%b addr=%0d",
                 name, k, wr_en_o, wr_addr_o, exp_wr, exp_addr);
      end
      step();
      model_ovf = nxt_ovf;
    end
    snk.valid = 1'b0; snk.sop = 1'b0; snk.eop = 1'b0;

    // ---------------- sort ----------------
    len = pkt.size();
    done_seen = 0;
    for (int c = 0; c < TO; c++) begin
      sort_done_i = (c == done_delay);
      #1;
      checks++;
      if (busy_o !== 1'b1 || snk.ready !== 1'b0 || sort_start_o !== (c == 0) ||
          err_timeout_o !== 1'b0 || src.valid !== 1'b0 || err_ovf_o !== model_ovf) begin
        failures++;
        $display("FAIL %s sort_cycle c=%0d busy=%b ready=%b start=%b tmo=%b valid=%b ovf=%b required 1 0 %b 0 0 %b",
                 name, c, busy_o, snk.ready, sort_start_o, err_timeout_o, src.valid, err_ovf_o,
                 (c == 0), model_ovf);
      end
      checks++;
      if (sort_len_o !== (AW+1)'(len) || sort_desc_o !== desc) begin
        failures++;
        $display("FAIL %s sort_latch len=%0d desc=%b required len=%0d desc=%b",
                 name, sort_len_o, sort_desc_o, len, desc);
      end
      if (sort_done_i) engine_sort();
      step();
      if (sort_done_i) begin done_seen = 1; break; end
    end
    sort_done_i = 1'b0;

    if (!done_seen) begin
      #1;
      checks++;
      if (err_timeout_o !== 1'b1 || clear_o !== 1'b1 || busy_o !== 1'b1 || src.valid !== 1'b0) begin
        failures++;
        $display("FAIL %s timeout_pulse tmo=%b clear=%b busy=%b valid=%b required 1 1 1 0",
                 name, err_timeout_o, clear_o, busy_o, src.valid);
      end
      step();
      #1;
      checks++;
      if (err_timeout_o !== 1'b0 || clear_o !== 1'b0 || busy_o !== 1'b0 || snk.ready !== 1'b1 ||
          src.valid !== 1'b0) begin
        failures++;
        $display("FAIL %s after_timeout tmo=%b clear=%b busy=%b ready=%b valid=%b required 0 0 0 1 0",
                 name, err_timeout_o, clear_o, busy_o, snk.ready, src.valid);
      end
      step();
      return;
    end

    // ---------------- output ----------------
    exp_q = pkt;
    if (desc) exp_q.rsort(); else exp_q.sort();
    finished = 0; prev_stall = 0; prev_q = '0; prev_sop = 0; prev_eop = 0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      case (ready_mode)
        0:       src.ready = 1'b1;
        1:       src.ready = (cyc % 3 == 0);
        default: src.ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (abort_after >= 0 && got_d.size() == abort_after) begin
        srst_n_i = 1'b0;
        step();
        srst_n_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || src.valid !== 1'b0 || snk.ready !== 1'b1 || sort_len_o !== '0 ||
            clear_o !== 1'b0 || err_ovf_o !== 1'b0 || rd_en_o !== 1'b0) begin
          failures++;
          $display("FAIL %s abort_reset busy=%b valid=%b ready=%b len=%0d clear=%b ovf=%b rd=%b required 0 0 1 0 0 0 0",
                   name, busy_o, src.valid, snk.ready, sort_len_o, clear_o, err_ovf_o, rd_en_o);
        end
        model_ovf = 0;
        step();
        return;
      end
      checks++;
      if (rd_en_o === 1'b1 && src.valid === 1'b1 && src.ready === 1'b0) begin
        failures++;
        $display("FAIL %s stalled_read cyc=%0d rd_en=1 required 0", name, cyc);
      end
      if (prev_stall) begin
        checks++;
        if (src.valid !== 1'b1 || q !== prev_q || src.sop !== prev_sop || src.eop !== prev_eop) begin
          failures++;
          $display("FAIL %s hold cyc=%0d valid=%b q=%h sop=%b eop=%b required 1 %h %b %b",
                   name, cyc, src.valid, q, src.sop, src.eop, prev_q, prev_sop, prev_eop);
        end
      end
      if (ready_mode == 0 && got_d.size() > 0) begin
        checks++;
        if (src.valid !== 1'b1) begin
          failures++;
          $display("FAIL %s gap cyc=%0d valid=%b required 1", name, cyc, src.valid);
        end
      end
      checks++;
      if (clear_o !== 1'b0 || busy_o !== 1'b1 || sort_start_o !== 1'b0) begin
        failures++;
        $display("FAIL %s output_status clear=%b busy=%b start=%b required 0 1 0",
                 name, clear_o, busy_o, sort_start_o);
      end
      if (src.valid === 1'b1 && src.ready === 1'b1) begin
        got_d.push_back(q); got_sop.push_back(src.sop); got_eop.push_back(src.eop);
        if (src.eop === 1'b1) finished = 1;
      end
      prev_stall = (src.valid === 1'b1) && (src.ready === 1'b0);
      prev_q = q; prev_sop = src.sop; prev_eop = src.eop;
      step();
    end
    src.ready = 1'b1;
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL %s output_timeout words=%0d required %0d", name, got_d.size(), len);
    end
    #1;
    checks++;
    if (clear_o !== 1'b1 || busy_o !== 1'b1 || src.valid !== 1'b0) begin
      failures++;
      $display("FAIL %s clear clear=%b busy=%b valid=%b required 1 1 0", name, clear_o, busy_o, src.valid);
    end
    step();
    #1;
    checks++;
    if (clear_o !== 1'b0 || busy_o !== 1'b0 || snk.ready !== 1'b1) begin
      failures++;
      $display("FAIL %s back_idle clear=%b busy=%b ready=%b required 0 0 1", name, clear_o, busy_o, snk.ready);
    end
    step();

    checks++;
    if (got_d.size() != len) begin
      failures++;
      $display("FAIL %s word_count got=%0d required %0d", name, got_d.size(), len);
    end
    for (int i = 0; i < got_d.size() && i < len; i++) begin
      checks++;
      if (got_d[i] !== exp_q[i] || got_sop[i] != (i == 0) || got_eop[i] != (i == len - 1)) begin
        failures++;
        $display("FAIL %s word%0d data=%h sop=%b eop=%b required %h %b %b",
                 name, i, got_d[i], got_sop[i], got_eop[i], exp_q[i], (i == 0), (i == len - 1));
      end
    end
    $display("%s: len=%0d desc=%b words_out=%0d", name, len, desc, got_d.size());
  endtask

  task automatic test_reset();
    srst_n_i = 1'b0; snk.valid = 1'b0; snk.sop = 1'b0; snk.eop = 1'b0;
    mode_desc_i = 1'b0; sort_done_i = 1'b0; src.ready = 1'b0; wr_data = '0; q = '0;
    model_ovf = 0;
    @(negedge clk_i);
    step(); step();
    srst_n_i = 1'b1;
    #1;
    checks++;
    if (snk.ready !== 1'b1 || busy_o !== 1'b0 || wr_en_o !== 1'b0 || sort_start_o !== 1'b0 ||
        sort_len_o !== '0 || sort_desc_o !== 1'b0 || rd_en_o !== 1'b0 || src.valid !== 1'b0 ||
        src.sop !== 1'b0 || src.eop !== 1'b0 || clear_o !== 1'b0 || err_ovf_o !== 1'b0 ||
        err_timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state ready=%b busy=%b wr=%b start=%b len=%0d desc=%b rd=%b v=%b clr=%b ovf=%b tmo=%b required ready=1 rest 0",
               snk.ready, busy_o, wr_en_o, sort_start_o, sort_len_o, sort_desc_o, rd_en_o,
               src.valid, clear_o, err_ovf_o, err_timeout_o);
    end
    step();
    $display("reset: checked idle outputs");
  endtask

  task automatic test_len5();
    build_packet(5, 0, 0);
    run_packet(1'b0, 0, 2, -1, "len5");
  endtask

  task automatic test_single();
    build_packet(1, 0, 0);
    run_packet(1'b1, 0, 0, -1, "single");
  endtask

  task automatic test_overflow();
    build_packet(20, 0, 0);
    run_packet(1'b0, 0, 3, -1, "overflow20");
  endtask

  task automatic test_backpressure();
    build_packet(9, 1, 1);
    run_packet(1'b1, 1, 5, -1, "backpressure");
  endtask

  task automatic test_timeout();
    build_packet(4, 0, 0);
    run_packet(1'b0, 0, -1, -1, "timeout");
  endtask

  task automatic test_done_at_limit();
    build_packet(6, 0, 0);
    run_packet(1'b1, 0, TO - 1, -1, "done_at_limit");
  endtask

  task automatic test_reset_mid_output();
    build_packet(8, 0, 0);
    run_packet(1'b0, 2, 1, 3, "abort_output");
    build_packet(3, 0, 0);
    run_packet(1'b1, 0, 2, -1, "after_abort");
  endtask

  task automatic test_restart();
    build_packet(18, 0, 0);
    stim[17].eop = 1'b0;
    for (int i = 0; i < 4; i++) stim.push_back('{8'($urandom), 1'b1, (i == 0), (i == 3)});
    run_packet(1'b1, 2, 4, -1, "restart");
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      build_packet($urandom_range(1, 20), 1, 1'($urandom_range(0, 1)));
      run_packet(1'($urandom_range(0, 1)), 2, $urandom_range(0, TO - 1), -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_len5();
    test_single();
    test_overflow();
    test_backpressure();
    test_timeout();
    test_done_at_limit();
    test_reset_mid_output();
    test_restart();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
